// File: rtl/dmem_ctrl.sv
// Data-side memory controller: decodes core loads/stores to on-chip RAM, MMIO
// (64-bit cycle counter, UART TX FIFO) or an unmapped hole; MMIO loads stall once.
module dmem_ctrl #(
    parameter int RAM_AW     = 12,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr,
    input  logic        mem_oe,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_we,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_RESP = 2'd2} state_t;

    logic [31:0] ram_mem [0:(2**RAM_AW)-1];
    logic [7:0]  fifo_mem [0:FIFO_DEPTH-1];

    state_t         state_q, state_d;
    logic           mem_ready_q, mem_ready_d;
    logic [31:0]    mem_rdata_q, mem_rdata_d;
    logic           tx_valid_q, tx_valid_d;
    logic [7:0]     tx_data_q, tx_data_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           ovf_q, ovf_d;
    logic [63:0]    cnt_q, cnt_d;
    logic [31:0]    hi_q, hi_d;

    logic [1:0]        sh_s;
    logic [3:0]        lane_we_s;
    logic [31:0]       wdata_al_s;
    logic              accept_s, is_load_s, is_ram_s, is_mmio_s;
    logic [RAM_AW-1:0] ram_idx_s;
    logic [25:0]       mmio_off_s;
    logic [31:0]       mmio_rd_s;
    logic              ram_we_s, push_req_s, push_ok_s, pop_s, full_s, stat_clr_s;

    // Request decode, lane alignment, FIFO bookkeeping and FSM next state.
    always_comb begin
        sh_s       = mem_addr[1:0];
        wdata_al_s = mem_wdata << {sh_s, 3'b000};
        case (sh_s)
            2'd0:    lane_we_s = mem_we;
            2'd1:    lane_we_s = {mem_we[2:0], 1'b0};
            2'd2:    lane_we_s = {mem_we[1:0], 2'b00};
            2'd3:    lane_we_s = {mem_we[0], 3'b000};
            default: lane_we_s = mem_we;
        endcase
        case (mem_addr[31:28])
            4'h0: begin is_ram_s = 1'b1; is_mmio_s = 1'b0; end
            4'h8: begin is_ram_s = 1'b0; is_mmio_s = 1'b1; end
            default: begin is_ram_s = 1'b0; is_mmio_s = 1'b0; end
        endcase
        accept_s   = mem_oe && (state_q != ST_WAIT);
        is_load_s  = (mem_we == 4'b0000);
        ram_idx_s  = mem_addr[RAM_AW+1:2];
        mmio_off_s = mem_addr[27:2];
        case (mmio_off_s)
            26'd0:   mmio_rd_s = cnt_q[31:0];
            26'd1:   mmio_rd_s = hi_q;
            26'd3:   mmio_rd_s = {ovf_q, 23'd0, 8'(count_q)};
            default: mmio_rd_s = 32'd0;
        endcase

        ram_we_s   = accept_s && is_ram_s && !is_load_s;
        push_req_s = accept_s && is_mmio_s && !is_load_s && (mmio_off_s == 26'd2) && lane_we_s[0];
        stat_clr_s = accept_s && is_mmio_s && !is_load_s && (mmio_off_s == 26'd3);
        pop_s      = tx_valid_q && tx_ready;
        full_s     = (count_q == CW'(FIFO_DEPTH));
        // A full FIFO still takes a push when the head leaves in the same cycle.
        push_ok_s  = push_req_s && (!full_s || pop_s);

        wr_ptr_d = push_ok_s ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop_s ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push_ok_s) - CW'(pop_s);

        ovf_d = ovf_q;
        if (stat_clr_s) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
        if (push_req_s && !push_ok_s) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_d;
        end

        tx_valid_d = (count_d != CW'(0));
        if (push_ok_s && (wr_ptr_q == rd_ptr_d)) begin
            tx_data_d = wdata_al_s[7:0];
        end else begin
            tx_data_d = fifo_mem[rd_ptr_d];
        end

        cnt_d       = cnt_q + 64'd1;
        hi_d        = hi_q;
        state_d     = state_q;
        mem_ready_d = mem_ready_q;
        mem_rdata_d = mem_rdata_q;
        case (state_q)
            ST_WAIT: begin
                state_d     = ST_RESP;
                mem_ready_d = 1'b1;
            end
            ST_IDLE, ST_RESP: begin
                state_d     = ST_IDLE;
                mem_ready_d = 1'b1;
                if (accept_s && is_load_s) begin
                    if (is_mmio_s) begin
                        state_d     = ST_WAIT;
                        mem_ready_d = 1'b0;
                        mem_rdata_d = mmio_rd_s;
                        if (mmio_off_s == 26'd0) begin
                            hi_d = cnt_q[63:32];
                        end else begin
                            hi_d = hi_q;
                        end
                    end else if (is_ram_s) begin
                        mem_rdata_d = ram_mem[ram_idx_s] >> {sh_s, 3'b000};
                    end else begin
                        mem_rdata_d = 32'd0;
                    end
                end else begin
                    mem_rdata_d = mem_rdata_q;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                mem_ready_d = 1'b1;
            end
        endcase
    end

    // Control state, response registers, FIFO pointers and cycle counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mem_ready_q <= 1'b1;
            mem_rdata_q <= 32'd0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= 8'd0;
            wr_ptr_q    <= PW'(0);
            rd_ptr_q    <= PW'(0);
            count_q     <= CW'(0);
            ovf_q       <= 1'b0;
            cnt_q       <= 64'd0;
            hi_q        <= 32'd0;
        end else begin
            state_q     <= state_d;
            mem_ready_q <= mem_ready_d;
            mem_rdata_q <= mem_rdata_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
        end
    end

    // RAM byte-lane writes; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (ram_we_s && lane_we_s[i]) begin
                ram_mem[ram_idx_s][8*i +: 8] <= wdata_al_s[8*i +: 8];
            end
        end
    end

    // UART FIFO storage.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            fifo_mem[wr_ptr_q] <= wdata_al_s[7:0];
        end
    end

    assign mem_ready = mem_ready_q;
    assign mem_rdata = mem_rdata_q;
    assign tx_valid  = tx_valid_q;
    assign tx_data   = tx_data_q;
endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: RAM lanes, MMIO stall, UART FIFO, mid-stall reset.
module tb_dmem_ctrl;
    logic        clk;
    logic        rst;
    logic [31:0] mem_addr;
    logic        mem_oe;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_we;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int total_cnt = 0;
    int bad_cnt   = 0;
    logic [63:0] ref_cnt;

    dmem_ctrl #(.RAM_AW(12), .FIFO_DEPTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_addr  (mem_addr),
        .mem_oe    (mem_oe),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference cycle count: value held during the current cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) ref_cnt <= 64'd0;
        else     ref_cnt <= ref_cnt + 64'd1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd);
        mem_addr = a; mem_we = we; mem_wdata = wd; mem_oe = 1'b1;
        step();
        mem_oe = 1'b0; mem_we = 4'b0000;
    endtask

    task automatic do_load(input logic [31:0] a, output logic [31:0] d, output int stalls);
        mem_addr = a; mem_we = 4'b0000; mem_wdata = 32'd0; mem_oe = 1'b1;
        step();
        mem_oe = 1'b0;
        stalls = 0;
        while (!mem_ready && stalls < 4) begin
            stalls++;
            step();
        end
        d = mem_rdata;
    endtask

    initial begin
        logic [31:0] d;
        int          st;
        logic [31:0] exp_lo;

        rst = 1'b1; mem_addr = 32'd0; mem_oe = 1'b0; mem_wdata = 32'd0;
        mem_we = 4'b0000; tx_ready = 1'b0;
        step(); step();
        chk("rst_ready", 64'(mem_ready), 64'd1);
        chk("rst_rdata", 64'(mem_rdata), 64'd0);
        chk("rst_txv",   64'(tx_valid),  64'd0);
        chk("rst_txd",   64'(tx_data),   64'd0);
        rst = 1'b0;
        step();

        // 1: word store / load
        do_store(32'h0000_0010, 4'b1111, 32'hDEAD_BEEF);
        do_load(32'h0000_0010, d, st);
        chk("lw_stall", 64'(st), 64'd0);
        chk("lw_data",  64'(d),  64'hDEAD_BEEF);

        // 2: byte and half lanes
        do_store(32'h0000_0013, 4'b0001, 32'h0000_00AB);
        do_load(32'h0000_0010, d, st);
        chk("sb_word", 64'(d), 64'hABAD_BEEF);
        do_load(32'h0000_0013, d, st);
        chk("lb_lane3", 64'(d), 64'h0000_00AB);
        do_store(32'h0000_0012, 4'b0011, 32'h0000_1234);
        do_load(32'h0000_0012, d, st);
        chk("lh_lane2", 64'(d), 64'h0000_1234);
        do_load(32'h0000_0010, d, st);
        chk("sh_word", 64'(d), 64'h1234_BEEF);

        // unmapped store is dropped, unmapped load returns 0
        do_store(32'h4000_0010, 4'b1111, 32'h5555_5555);
        do_load(32'h0000_0010, d, st);
        chk("unmap_st_drop", 64'(d), 64'h1234_BEEF);

        // 3: MMIO stall, held request ignored during WAIT
        do_store(32'h0000_0020, 4'b1111, 32'h1111_1111);
        mem_addr = 32'h8000_0000; mem_we = 4'b0000; mem_oe = 1'b1;
        exp_lo = ref_cnt[31:0];
        step();
        chk("mmio_wait_rdy", 64'(mem_ready), 64'd0);
        mem_addr = 32'h0000_0020; mem_we = 4'b1111; mem_wdata = 32'h2222_2222;
        step();
        mem_oe = 1'b0; mem_we = 4'b0000;
        chk("mmio_resp_rdy", 64'(mem_ready), 64'd1);
        chk("cycle_lo", 64'(mem_rdata), 64'(exp_lo));
        do_load(32'h0000_0020, d, st);
        chk("wait_st_ignored", 64'(d), 64'h1111_1111);
        do_load(32'h8000_0004, d, st);
        chk("hi_stall", 64'(st), 64'd1);
        chk("cycle_hi", 64'(d), 64'd0);
        exp_lo = ref_cnt[31:0];
        do_load(32'h8000_0000, d, st);
        chk("cycle_lo2", 64'(d), 64'(exp_lo));

        // 4: overflow with 9 pushes, in-order drain, clear
        tx_ready = 1'b0;
        for (int i = 1; i <= 9; i++) do_store(32'h8000_0008, 4'b0001, 32'(i));
        do_load(32'h8000_000C, d, st);
        chk("stat_stall", 64'(st), 64'd1);
        chk("stat_ovf", 64'(d), 64'h8000_0008);
        tx_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk("drain_valid", 64'(tx_valid), 64'd1);
            chk("drain_data",  64'(tx_data),  64'(i));
            step();
        end
        chk("drain_empty", 64'(tx_valid), 64'd0);
        tx_ready = 1'b0;
        do_load(32'h8000_000C, d, st);
        chk("stat_sticky", 64'(d), 64'h8000_0000);
        do_store(32'h8000_000C, 4'b1111, 32'd0);
        do_load(32'h8000_000C, d, st);
        chk("stat_clr", 64'(d), 64'd0);
        do_load(32'h8000_0008, d, st);
        chk("uart_rd0", 64'(d), 64'd0);

        // 5: full FIFO with simultaneous push and pop
        for (int i = 0; i < 8; i++) do_store(32'h8000_0008, 4'b0001, 32'h10 + 32'(i));
        tx_ready = 1'b1;
        do_store(32'h8000_0008, 4'b0001, 32'h18);
        tx_ready = 1'b0;
        chk("pp_head", 64'(tx_data), 64'h11);
        do_load(32'h8000_000C, d, st);
        chk("pp_stat", 64'(d), 64'h0000_0008);
        tx_ready = 1'b1;
        for (int i = 0; i < 7; i++) step();
        chk("pp_last", 64'(tx_data), 64'h18);
        step();
        chk("pp_empty", 64'(tx_valid), 64'd0);
        tx_ready = 1'b0;

        // 6: reset during WAIT
        do_store(32'h8000_0008, 4'b0001, 32'h77);
        chk("pre_rst_txv", 64'(tx_valid), 64'd1);
        mem_addr = 32'h8000_0000; mem_we = 4'b0000; mem_oe = 1'b1;
        step();
        mem_oe = 1'b0;
        chk("pre_rst_wait", 64'(mem_ready), 64'd0);
        rst = 1'b1;
        #1;
        chk("rst_async_rdy", 64'(mem_ready), 64'd1);
        chk("rst_async_txv", 64'(tx_valid),  64'd0);
        step();
        rst = 1'b0;
        do_load(32'h8000_0000, d, st);
        chk("rst_cnt0", 64'(d), 64'd0);
        do_load(32'h8000_000C, d, st);
        chk("rst_fifo0", 64'(d), 64'd0);
        do_load(32'h0000_0010, d, st);
        chk("ram_kept", 64'(d), 64'h1234_BEEF);
        do_load(32'h4000_0000, d, st);
        chk("unmap_stall", 64'(st), 64'd0);
        chk("unmap_ld0", 64'(d), 64'd0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end
endmodule
